// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: FU result / CDB packet types and arbiter defaults
package cdb_arbiter_pkg;
  localparam int DEFAULT_NUM_FU = 4;
  localparam int ROB_TAG_W = 5;
  typedef struct packed {
    logic                 done;
    logic [31:0]          v;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 take_branch;
    logic [31:0]          branch_loc;
    logic                 mispredicted;
    logic [31:0]          origin_PC;
  } FU_OUT_PACKET;
  typedef FU_OUT_PACKET CDB_PACKET;
endpackage

// File: rtl/rr_priority_sel.sv
// rr_priority_sel: combinational round-robin pick of the first request at or after ptr
module rr_priority_sel #(
  parameter int N = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             grant_valid,
  output logic [N-1:0]     onehot
);
  logic [PTR_W:0]   sum [N];
  logic [PTR_W-1:0] rot [N];
  for (genvar k = 0; k < N; k++) begin : g_rot
    assign sum[k] = {1'b0, ptr} + (PTR_W+1)'(k);
    assign rot[k] = sum[k] >= (PTR_W+1)'(N) ? PTR_W'(sum[k] - (PTR_W+1)'(N)) : sum[k][PTR_W-1:0];
  end
  // scan farthest offset first so the nearest requester overwrites
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[rot[k]]) begin
        grant = rot[k];
        grant_valid = 1'b1;
      end
  end
  assign onehot = grant_valid ? N'(1) << grant : '0;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin selection of one FU result per cycle onto the registered CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = DEFAULT_NUM_FU,
  parameter int PTR_W = $clog2(NUM_FU)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  FU_OUT_PACKET      fu_out_packet [NUM_FU],
  output logic [NUM_FU-1:0] ack,
  output CDB_PACKET         cdb_packet,
  output logic [PTR_W-1:0]  cdb_grant_idx,
  output logic [31:0]       cdb_count
);
  logic [NUM_FU-1:0] req, onehot;
  logic [PTR_W-1:0]  rr_ptr, grant;
  logic              grant_valid;
  for (genvar i = 0; i < NUM_FU; i++) begin : g_req
    assign req[i] = fu_out_packet[i].done;
  end
  rr_priority_sel #(.N(NUM_FU), .PTR_W(PTR_W)) u_sel (
    .req(req),
    .ptr(rr_ptr),
    .grant(grant),
    .grant_valid(grant_valid),
    .onehot(onehot)
  );
  // squash acks every requester so all FU output registers drain at once
  assign ack = reset ? '0 : squash ? req : onehot;
  always_ff @(posedge clock)
    if (reset) begin
      cdb_packet <= '0;
      cdb_grant_idx <= '0;
      cdb_count <= '0;
      rr_ptr <= '0;
    end else if (squash) begin
      cdb_packet <= '0;
      rr_ptr <= '0;
    end else if (grant_valid) begin
      cdb_packet <= fu_out_packet[grant];
      cdb_packet.done <= 1'b1;
      cdb_grant_idx <= grant;
      cdb_count <= cdb_count + 32'd1;
      rr_ptr <= grant == PTR_W'(NUM_FU - 1) ? '0 : grant + 1'b1;
    end else
      cdb_packet <= '0;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus random stimulus against a round-robin reference model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  localparam int N = 4;
  logic         clock = 1'b0;
  logic         reset, squash;
  FU_OUT_PACKET fu [N];
  logic [N-1:0] ack;
  FU_OUT_PACKET cdb_packet;
  logic [1:0]   cdb_grant_idx;
  logic [31:0]  cdb_count;
  FU_OUT_PACKET m_pkt;
  logic [1:0]   m_idx;
  logic [31:0]  m_cnt;
  int           m_ptr;
  int           checks = 0, errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clock(clock),
    .reset(reset),
    .squash(squash),
    .fu_out_packet(fu),
    .ack(ack),
    .cdb_packet(cdb_packet),
    .cdb_grant_idx(cdb_grant_idx),
    .cdb_count(cdb_count)
  );

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      fu[i].done = r[i];
      fu[i].v = $urandom;
      fu[i].rob_tag = 5'($urandom);
      fu[i].take_branch = 1'($urandom);
      fu[i].branch_loc = $urandom;
      fu[i].mispredicted = 1'($urandom);
      fu[i].origin_PC = $urandom;
    end
  endtask

  task automatic run(logic sq, logic rs);
    logic [N-1:0] r, ea;
    int g;
    squash = sq;
    reset = rs;
    for (int i = 0; i < N; i++) r[i] = fu[i].done;
    g = pick(r, m_ptr);
    ea = rs ? '0 : sq ? r : (g < 0 ? '0 : N'(1) << g);
    @(negedge clock);
    chk("ack", 128'(ack), 128'(ea));
    chk("cdb_packet", 128'(cdb_packet), 128'(m_pkt));
    chk("cdb_grant_idx", 128'(cdb_grant_idx), 128'(m_idx));
    chk("cdb_count", 128'(cdb_count), 128'(m_cnt));
    if (rs) begin
      m_pkt = '0; m_idx = '0; m_cnt = '0; m_ptr = 0;
    end else if (sq) begin
      m_pkt = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_pkt = fu[g];
      m_pkt.done = 1'b1;
      m_idx = 2'(g);
      m_cnt++;
      m_ptr = (g + 1) % N;
    end else
      m_pkt = '0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    squash = 1'b0;
    load('0);
    m_pkt = '0; m_idx = '0; m_cnt = '0; m_ptr = 0;
    @(posedge clock);
    #1;
    // reset held, then released idle
    load(N'($urandom)); run(1'b0, 1'b1);
    load(4'b1111);      run(1'b1, 1'b1);
    load('0);           run(1'b0, 1'b0);
    // single FU2 result
    load(4'b0100);
    fu[2].rob_tag = 5'd5;
    fu[2].v = 32'h1234;
    run(1'b0, 1'b0);
    chk("t2_done", 128'(cdb_packet.done), 128'(1));
    chk("t2_tag", 128'(cdb_packet.rob_tag), 128'(5));
    chk("t2_v", 128'(cdb_packet.v), 128'(32'h1234));
    chk("t2_idx", 128'(cdb_grant_idx), 128'(2));
    chk("t2_count", 128'(cdb_count), 128'(1));
    load('0); run(1'b0, 1'b0);
    chk("t2_drop", 128'(cdb_packet.done), 128'(0));
    // pointer back to 0, then all FUs requesting for 8 cycles
    load('0); run(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      load(4'b1111); run(1'b0, 1'b0);
      chk("t3_order", 128'(cdb_grant_idx), 128'(c % N));
    end
    chk("t3_count", 128'(cdb_count), 128'(9));
    // move pointer to 3, then req=1001 alternates 3,0,3
    for (int c = 0; c < 3; c++) begin load(4'b1111); run(1'b0, 1'b0); end
    load(4'b1001); run(1'b0, 1'b0);
    chk("t4_wrap3", 128'(cdb_grant_idx), 128'(3));
    load(4'b1001); run(1'b0, 1'b0);
    chk("t4_wrap0", 128'(cdb_grant_idx), 128'(0));
    load(4'b1001); run(1'b0, 1'b0);
    chk("t4_again3", 128'(cdb_grant_idx), 128'(3));
    // squash drains and suppresses broadcast
    load(4'b0111); run(1'b1, 1'b0);
    chk("t5_done", 128'(cdb_packet.done), 128'(0));
    chk("t5_count", 128'(cdb_count), 128'(15));
    // reset with a grant in flight
    load(4'b1111); run(1'b0, 1'b0);
    load(4'b1111); run(1'($urandom), 1'b1);
    chk("t6_count", 128'(cdb_count), 128'(0));
    chk("t6_done", 128'(cdb_packet.done), 128'(0));
    // random traffic with occasional squash and reset
    for (int c = 0; c < 400; c++) begin
      load(N'($urandom));
      run($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end
    load('0); run(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
